// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART command framer.
// Holds the frame marker bytes, the ACK/NAK reply bytes, the framer state
// encoding and the error cause codes reported on err_code.
package uart_frame_pkg;

    localparam logic [7:0] FRAME_HDR  = 8'hA5;
    localparam logic [7:0] FRAME_TAIL = 8'h5A;
    localparam logic [7:0] ACK_BYTE   = 8'h06;
    localparam logic [7:0] NAK_BYTE   = 8'h15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2,
        ST_TAIL    = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_CSUM    = 2'b01;
    localparam logic [1:0] ERR_TAIL    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/frame_timer.sv
// Inter-byte timeout counter for the UART command framer.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   run        : framer is inside a frame (counter enabled)
//   clear      : a byte arrived this cycle (restart the count)
//   expire     : combinational flag, high in the cycle the count reaches
//                TIMEOUT_CYCLES-1 with no byte arriving
// Only instantiated when UART_FRAME_TIMEOUT_EN is defined.
module frame_timer
    import uart_frame_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clear,
    output logic expire
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || clear) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A byte in the expiry cycle takes precedence over the timeout.
    assign expire = run && !clear && (cnt == LAST);

endmodule

// File: rtl/uart_frame_rx.sv
// Byte-to-word command framer.
// Collects 7-byte frames (A5, P3 P2 P1 P0, XOR checksum, 5A) from the UART
// byte receiver, delivers the validated 32-bit payload and posts an ACK/NAK
// byte for the transmit path after every completed or aborted frame.
// Ports:
//   clk, rst_n            : system clock, asynchronous active-low reset
//   rx_data, rx_valid     : received byte and its one-cycle strobe
//   frame_data            : last good payload (P3 in the MSB), held
//   frame_valid           : one-cycle pulse when frame_data updates
//   frame_err             : one-cycle pulse on a bad or aborted frame
//   err_code              : cause of the last error (01 csum, 10 tail, 11 timeout)
//   ack_byte, ack_valid   : pending reply byte and its valid flag
//   ack_ready             : transmitter accepts the reply on valid && ready
// Build option: define UART_FRAME_TIMEOUT_EN to abort frames whose bytes are
// more than TIMEOUT_CYCLES clocks apart (err_code 11). Without it the framer
// waits indefinitely inside a frame.
module uart_frame_rx
    import uart_frame_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [31:0] frame_data,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [7:0]  ack_byte,
    output logic        ack_valid,
    input  logic        ack_ready
);

    if (TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("uart_frame_rx: TIMEOUT_CYCLES must be at least 2");
    end

    state_t      state, state_next;
    logic [31:0] sr;
    logic [1:0]  count;
    logic [7:0]  csum;
    logic        csum_bad;
    logic        timeout;
    logic        done_ok, done_err;
    logic [1:0]  err_next;

`ifdef UART_FRAME_TIMEOUT_EN
    frame_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (state != ST_IDLE),
        .clear  (rx_valid),
        .expire (timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        done_ok    = 1'b0;
        done_err   = 1'b0;
        err_next   = ERR_NONE;
        case (state)
            ST_IDLE: begin
                if (rx_valid && rx_data == FRAME_HDR) begin
                    state_next = ST_PAYLOAD;
                end
            end
            ST_PAYLOAD: begin
                if (rx_valid && count == 2'd3) begin
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (rx_valid) begin
                    state_next = ST_TAIL;
                end
            end
            ST_TAIL: begin
                if (rx_valid) begin
                    state_next = ST_IDLE;
                    // A wrong tail is reported in preference to a bad checksum.
                    if (rx_data != FRAME_TAIL) begin
                        done_err = 1'b1;
                        err_next = ERR_TAIL;
                    end else if (csum_bad) begin
                        done_err = 1'b1;
                        err_next = ERR_CSUM;
                    end else begin
                        done_ok = 1'b1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // timeout is only raised inside a frame and never alongside rx_valid.
        if (timeout) begin
            state_next = ST_IDLE;
            done_err   = 1'b1;
            err_next   = ERR_TIMEOUT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr          <= '0;
            count       <= '0;
            csum        <= '0;
            csum_bad    <= 1'b0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= ERR_NONE;
            ack_byte    <= 8'h00;
            ack_valid   <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;

            if (rx_valid) begin
                case (state)
                    ST_IDLE: begin
                        if (rx_data == FRAME_HDR) begin
                            sr       <= '0;
                            count    <= '0;
                            csum     <= '0;
                            csum_bad <= 1'b0;
                        end
                    end
                    ST_PAYLOAD: begin
                        sr    <= {sr[23:0], rx_data};
                        csum  <= csum ^ rx_data;
                        count <= count + 2'd1;
                    end
                    ST_CHECK: csum_bad <= (rx_data != csum);
                    default: ;
                endcase
            end

            if (done_ok) begin
                frame_data  <= sr;
                frame_valid <= 1'b1;
            end
            if (done_err) begin
                frame_err <= 1'b1;
                err_code  <= err_next;
            end

            // A new post overrides both a pending reply and a same-cycle handshake.
            if (done_ok || done_err) begin
                ack_valid <= 1'b1;
                ack_byte  <= done_ok ? ACK_BYTE : NAK_BYTE;
            end else if (ack_valid && ack_ready) begin
                ack_valid <= 1'b0;
            end
        end
    end

endmodule
